mux_nto1_rr_reg: RTL
====================

Name: mux_nto1_rr_reg

Overview:
Parametrised N-input, WIDTH-bit registered multiplexer with a valid/ready handshake on every input and on the output. It supersedes the combinational 2:1 5-bit mux used for write-register selection wherever a source must be held under backpressure. There are two modes: externally selected, or round-robin arbitration among the valid inputs. It has one output register stage and sustains one transfer per cycle.

Parameters:
WIDTH, 5, data width per channel in bits.
N, 4, number of input channels (N >= 2).
MODE, 0, 0 = external select (sel port); 1 = round-robin arbitration, sel ignored.
SELW, derived localparam = clog2(N), width of channel index.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
in_data  in  N*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
in_valid  in  N  per-channel valid.
in_ready  out  N  per-channel ready; at most one bit is high per cycle.
sel  in  SELW  channel select, used in MODE 0 only.
out_data  out  WIDTH  registered selected data.
out_valid  out  1  output register holds data.
out_ready  in  1  downstream accepts out_data this cycle.
out_src  out  SELW  index of the channel that supplied out_data.

Behaviour:
- Reset: one clk edge with reset=1 clears out_valid=0, out_data=0, out_src=0, and rr pointer ptr=0. reset wins over every simultaneous event. Reset mid-transfer discards the held word.
- load = ~out_valid | out_ready. This is the output register state: EMPTY (out_valid=0) or FULL (out_valid=1).
- Grant (combinational):
  - MODE 0: the grant goes to channel sel if sel < N and in_valid[sel]=1; otherwise there is no grant. An out-of-range sel never grants.
  - MODE 1: the grant goes to the first i with in_valid[i]=1, searching ptr, ptr+1, ... and wrapping modulo N.
- in_ready[g] = load for the granted channel g. All other bits are 0. in_ready is 0 everywhere when there is no grant.
- Transfer occurs when in_valid[g] & in_ready[g]. On that clk edge: out_data <= in_data[g], out_src <= g, out_valid <= 1.
- Latency: one cycle from the input handshake to out_valid.
- Drain without refill (out_valid & out_ready, no grant): out_valid <= 0. out_data and out_src keep their last values.
- Simultaneous drain and refill: the new word loads and out_valid stays 1. Throughput is 1 word/cycle.
- Backpressure (out_valid & ~out_ready): out_data, out_src and out_valid are held stable, and all in_ready are 0.
- ptr (MODE 1) advances only on a transfer: ptr <= (g == N-1) ? 0 : g+1. It is unchanged when idle or stalled.
- In MODE 0, ptr is unused and stays 0.
- in_valid may drop without a handshake. There is no input-side retention.

Decomposition:
- Shared constants header: MUX_MODE_SEL = 0, MUX_MODE_RR = 1, and a clog2 function for SELW.
- One sub-module: rr_arbiter (N, SELW). Inputs are req[N] and ptr. Outputs are gnt_valid and gnt_idx. It is purely combinational rotate / priority-encode / unrotate logic and is instantiated only when MODE = 1.
- The output register, load logic and ptr register stay in mux_nto1_rr_reg.

Test Plan:
1. Reset: hold reset=1 for 2 edges with all in_valid=1 → out_valid=0, out_data=00000, out_src=0, in_ready=0000 during reset; the first transfer occurs on the first edge after release.
2. MODE 0: sel=0, in0=00010, in1=00011, in_valid=0011, out_ready=1 → next edge out_data=00010, out_src=0. Then sel=1 → out_data=00011, out_src=1. Then sel=2 with in_valid[2]=0 → in_ready=0000 and out_valid drops.
3. Backpressure: out_valid=1 with out_data=00011, out_ready=0 for 3 cycles while inputs change → out_data stays 00011 and in_ready=0000. On out_ready=1, the word drains and the granted input loads in the same edge.
4. MODE 1 fairness: in_valid=1111, in_i=i+1, out_ready=1 for 5 cycles → out_src sequence 0,1,2,3,0 and out_data 00001,00010,00011,00100,00001.
5. MODE 1 sparse and wrap: in_valid=1010, out_ready=1 → out_src 1,3,1,3. Stall for one cycle, then resume → the sequence continues without skipping a channel.
6. Reset mid-operation: out_valid=1 with out_ready=0 and ptr=2, then reset for 1 edge → out_valid=0 and ptr=0. With in_valid=1111 afterwards, the first out_src is 0.

Source files
------------

// File: rtl/mux_nto1_rr_reg_pkg.sv
// Shared constants for the registered N:1 mux: mode encodings and the
// index-width helper used to size channel selects.
package mux_nto1_rr_reg_pkg;

    localparam int unsigned MUX_MODE_SEL = 0;
    localparam int unsigned MUX_MODE_RR  = 1;

    // Never returns 0 so a select port always has at least one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_nto1_rr_reg_rr_arbiter.sv
// Combinational round-robin arbiter: rotates requests so ptr sits at bit 0,
// priority-encodes the lowest set bit, then rotates the index back.
module mux_nto1_rr_reg_rr_arbiter
    import mux_nto1_rr_reg_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    logic [N-1:0]    rot;
    logic [SELW-1:0] enc;
    logic [SELW-1:0] src_idx;

    always_comb begin
        rot     = '0;
        src_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            src_idx = SELW'((32'(ptr) + i) % N);
            rot[i]  = req[src_idx];
        end
    end

    always_comb begin
        enc = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = SELW'(i);
            end
        end
    end

    assign gnt_valid = |req;
    assign gnt_idx   = SELW'((32'(enc) + 32'(ptr)) % N);

endmodule

// File: rtl/mux_nto1_rr_reg.sv
// Registered N:1 mux with valid/ready on every channel; the source is chosen
// either by an external select or by round-robin arbitration over valid inputs.
module mux_nto1_rr_reg
    import mux_nto1_rr_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned N     = 4,
    parameter int unsigned MODE  = MUX_MODE_SEL,
    localparam int unsigned SELW = clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_src
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_src_q, out_src_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             gnt_valid;
    logic [SELW-1:0]  gnt_idx;
    logic             load;
    logic             xfer;

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            logic unused_sel;
            assign unused_sel = ^sel;

            mux_nto1_rr_reg_rr_arbiter #(
                .N    (N),
                .SELW (SELW)
            ) u_arb (
                .req       (in_valid),
                .ptr       (ptr_q),
                .gnt_valid (gnt_valid),
                .gnt_idx   (gnt_idx)
            );
        end else begin : g_sel
            // An out-of-range select must never grant, even with all inputs valid.
            always_comb begin
                gnt_valid = 1'b0;
                gnt_idx   = sel;
                if (32'(sel) < N) begin
                    gnt_valid = in_valid[sel];
                end
            end
        end
    endgenerate

    assign load = ~out_valid_q | out_ready;
    // Reset gates the handshake so no upstream word is consumed and then lost.
    assign xfer = gnt_valid & load & ~reset;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[32'(gnt_idx)*WIDTH +: WIDTH];
            out_src_d   = gnt_idx;
            if (MODE == MUX_MODE_RR) begin
                ptr_d = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(in_ready));
            assert (32'(ptr_q) < N);
        end
    end
`endif

endmodule
